// File: rtl/sliding_window_agg.sv
// Sliding-window aggregator: multi-lane samples enter a small FIFO, are drained
// one per cycle into a ring of time buckets, and the combined value of all
// buckets is published at the end of every bucket period.
module sliding_window_agg #(
  parameter int DATA_W        = 64,
  parameter int LANES         = 2,
  parameter int QUEUE_DEPTH   = 4,
  parameter int NUM_BUCKETS   = 2,
  parameter int BUCKET_PERIOD = 5,
  parameter int MODE          = 0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           en,
  input  logic [LANES*DATA_W-1:0]        input_x,
  input  logic [LANES-1:0]               new_input,
  output logic [DATA_W-1:0]              out_val,
  output logic                           out_valid,
  output logic [$clog2(QUEUE_DEPTH):0]   q_count,
  output logic                           dropped,
  output logic [$clog2(NUM_BUCKETS)-1:0] cur_bucket
);

  localparam int PTR_W = $clog2(QUEUE_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int BKT_W = $clog2(NUM_BUCKETS);
  localparam int TMR_W = $clog2(BUCKET_PERIOD);
  localparam logic [DATA_W-1:0] IDENTITY =
    (MODE == 2) ? {1'b1, {(DATA_W-1){1'b0}}} : '0;

  // Folds one popped sample into a bucket accumulator.
  function automatic logic [DATA_W-1:0] foldSample(input logic [DATA_W-1:0] acc,
                                                   input logic [DATA_W-1:0] smp);
    logic [DATA_W-1:0] res;
    if (MODE == 1) begin
      res = acc + DATA_W'(1);
    end else if (MODE == 2) begin
      res = ($signed(smp) > $signed(acc)) ? smp : acc;
    end else begin
      res = acc + smp;
    end
    return res;
  endfunction

  // Combines two bucket values; counts add just like sums.
  function automatic logic [DATA_W-1:0] combine(input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b);
    logic [DATA_W-1:0] res;
    if (MODE == 2) begin
      res = ($signed(b) > $signed(a)) ? b : a;
    end else begin
      res = a + b;
    end
    return res;
  endfunction

  logic [DATA_W-1:0] fifo_q [QUEUE_DEPTH];
  logic [DATA_W-1:0] fifo_d [QUEUE_DEPTH];
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              dropped_q, dropped_d;

  logic [DATA_W-1:0] bucket_q [NUM_BUCKETS];
  logic [DATA_W-1:0] bucket_d [NUM_BUCKETS];
  logic [DATA_W-1:0] bucketFold [NUM_BUCKETS];
  logic [BKT_W-1:0]  cur_q, cur_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic [DATA_W-1:0] out_val_q, out_val_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] aggregate;

  logic              pop;
  logic [DATA_W-1:0] popData;
  logic              expire;
  logic [CNT_W-1:0]  freeSlots;
  logic [CNT_W-1:0]  accepted;

  assign pop     = en && (count_q != '0);
  assign popData = fifo_q[rd_ptr_q];
  assign expire  = en && (timer_q == TMR_W'(BUCKET_PERIOD - 1));

  // FIFO push/pop: the slot freed by this cycle's pop may be refilled by a lane.
  always_comb begin
    fifo_d    = fifo_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q + PTR_W'(pop);
    dropped_d = 1'b0;
    accepted  = '0;
    freeSlots = CNT_W'(QUEUE_DEPTH) - count_q + CNT_W'(pop);
    for (int k = 0; k < LANES; k++) begin
      if (en && new_input[k]) begin
        if (accepted < freeSlots) begin
          fifo_d[wr_ptr_d] = input_x[k*DATA_W +: DATA_W];
          wr_ptr_d         = wr_ptr_d + 1'b1;
          accepted         = accepted + 1'b1;
        end else begin
          dropped_d = 1'b1;
        end
      end
    end
    count_d = count_q + accepted - CNT_W'(pop);
  end

  // Bucket folding, window aggregation, timer and bucket rotation.
  always_comb begin
    bucketFold = bucket_q;
    if (pop) begin
      bucketFold[cur_q] = foldSample(bucket_q[cur_q], popData);
    end
    aggregate = bucketFold[0];
    for (int i = 1; i < NUM_BUCKETS; i++) begin
      aggregate = combine(aggregate, bucketFold[i]);
    end
    bucket_d    = bucketFold;
    cur_d       = cur_q;
    timer_d     = timer_q;
    out_val_d   = out_val_q;
    out_valid_d = 1'b0;
    if (en) begin
      timer_d = timer_q + 1'b1;
    end
    if (expire) begin
      timer_d          = '0;
      out_val_d        = aggregate;
      out_valid_d      = 1'b1;
      cur_d            = (cur_q == BKT_W'(NUM_BUCKETS - 1)) ? '0 : cur_q + 1'b1;
      bucket_d[cur_d]  = IDENTITY;
    end
  end

  // State registers; reset discards queued samples and partial buckets.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < QUEUE_DEPTH; i++) fifo_q[i] <= '0;
      for (int i = 0; i < NUM_BUCKETS; i++) bucket_q[i] <= IDENTITY;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      dropped_q   <= 1'b0;
      cur_q       <= '0;
      timer_q     <= '0;
      out_val_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      fifo_q      <= fifo_d;
      bucket_q    <= bucket_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      dropped_q   <= dropped_d;
      cur_q       <= cur_d;
      timer_q     <= timer_d;
      out_val_q   <= out_val_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_val    = out_val_q;
  assign out_valid  = out_valid_q;
  assign q_count    = count_q;
  assign dropped    = dropped_q;
  assign cur_bucket = cur_q;

endmodule

// File: tb/tb_sliding_window_agg.sv
// Scoreboard bench for sliding_window_agg: three instances (sum, count, max)
// share stimulus; a window-epoch reference model predicts every output.
module tb_sliding_window_agg;

  localparam int DW = 64;
  localparam int LN = 2;
  localparam int QD = 4;
  localparam int NB = 2;
  localparam int BP = 5;
  localparam logic [63:0] MOST_NEG = 64'h8000_0000_0000_0000;

  typedef struct { logic [63:0] val; int epoch; } HistEntry;
  typedef struct { logic [63:0] sum; logic [63:0] cnt; logic [63:0] max; } WindowResult;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic en = 1'b0;
  logic clkRun = 1'b0;
  logic [LN*DW-1:0] inputX = '0;
  logic [LN-1:0] newInput = '0;

  logic [63:0] outVal0, outVal1, outVal2;
  logic outValid0, outValid1, outValid2;
  logic [2:0] qCount0, qCount1, qCount2;
  logic dropped0, dropped1, dropped2;
  logic [0:0] curBucket0, curBucket1, curBucket2;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [63:0] mq[$];
  HistEntry hist[$];
  WindowResult sb[$];
  int epoch = 0;
  int phase = 0;
  int expQ = 0;
  logic expDropped = 1'b0;
  logic expValid = 1'b0;
  logic [63:0] last0 = '0, last1 = '0, last2 = '0;

  // Observation logs for directed scenarios
  logic [63:0] seen0[$], seen1[$], seen2[$];
  int seenQ[$];
  logic seenDrop[$];

  sliding_window_agg #(.DATA_W(DW), .LANES(LN), .QUEUE_DEPTH(QD), .NUM_BUCKETS(NB),
                       .BUCKET_PERIOD(BP), .MODE(0)) dutSum (
    .clk(clk), .rst(rst), .en(en), .input_x(inputX), .new_input(newInput),
    .out_val(outVal0), .out_valid(outValid0), .q_count(qCount0),
    .dropped(dropped0), .cur_bucket(curBucket0));

  sliding_window_agg #(.DATA_W(DW), .LANES(LN), .QUEUE_DEPTH(QD), .NUM_BUCKETS(NB),
                       .BUCKET_PERIOD(BP), .MODE(1)) dutCount (
    .clk(clk), .rst(rst), .en(en), .input_x(inputX), .new_input(newInput),
    .out_val(outVal1), .out_valid(outValid1), .q_count(qCount1),
    .dropped(dropped1), .cur_bucket(curBucket1));

  sliding_window_agg #(.DATA_W(DW), .LANES(LN), .QUEUE_DEPTH(QD), .NUM_BUCKETS(NB),
                       .BUCKET_PERIOD(BP), .MODE(2)) dutMax (
    .clk(clk), .rst(rst), .en(en), .input_x(inputX), .new_input(newInput),
    .out_val(outVal2), .out_valid(outValid2), .q_count(qCount2),
    .dropped(dropped2), .cur_bucket(curBucket2));

  // Free-running clock once released, so reset can first be checked clockless
  initial begin
    wait (clkRun);
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Window of expiry E holds every pop tagged with an epoch in E-NB+1..E
  function automatic WindowResult windowAgg();
    WindowResult r;
    r.sum = '0;
    r.cnt = '0;
    r.max = MOST_NEG;
    foreach (hist[i]) begin
      if (hist[i].epoch > epoch - NB) begin
        r.sum = r.sum + hist[i].val;
        r.cnt = r.cnt + 64'd1;
        if ($signed(hist[i].val) > $signed(r.max)) r.max = hist[i].val;
      end
    end
    return r;
  endfunction

  function automatic void modelReset();
    mq.delete();
    hist.delete();
    sb.delete();
    epoch = 0;
    phase = 0;
    expQ = 0;
    expDropped = 1'b0;
    expValid = 1'b0;
    last0 = '0;
    last1 = '0;
    last2 = '0;
  endfunction

  // One clock edge of behaviour: pop oldest, push lanes into space left, expire
  function automatic void modelStep(input logic enV, input logic [LN-1:0] nv,
                                    input logic [63:0] x0, input logic [63:0] x1);
    HistEntry h;
    WindowResult r;
    logic [63:0] lane [LN];
    lane[0] = x0;
    lane[1] = x1;
    expValid = 1'b0;
    expDropped = 1'b0;
    if (enV) begin
      if (mq.size() > 0) begin
        h.val = mq.pop_front();
        h.epoch = epoch;
        hist.push_back(h);
      end
      for (int k = 0; k < LN; k++) begin
        if (nv[k]) begin
          if (mq.size() < QD) mq.push_back(lane[k]);
          else expDropped = 1'b1;
        end
      end
      if (phase == BP - 1) begin
        r = windowAgg();
        sb.push_back(r);
        last0 = r.sum;
        last1 = r.cnt;
        last2 = r.max;
        expValid = 1'b1;
        epoch++;
        phase = 0;
        while (hist.size() > 0 && hist[0].epoch <= epoch - NB) void'(hist.pop_front());
      end else begin
        phase++;
      end
    end
    expQ = mq.size();
  endfunction

  // Drives one cycle of inputs on the falling edge and advances the model
  task automatic applyStimulus(input logic enV, input logic [LN-1:0] nv,
                               input logic [63:0] x0, input logic [63:0] x1);
    @(negedge clk);
    rst = 1'b0;
    en = enV;
    newInput = nv;
    inputX = {x1, x0};
    modelStep(enV, nv, x0, x1);
  endtask

  task automatic runIdle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b1, 2'b00, 64'd0, 64'd0);
  endtask

  // Mid-cycle asynchronous reset, held across the following rising edge
  task automatic doReset();
    @(negedge clk);
    en = 1'b0;
    newInput = '0;
    #2;
    rst = 1'b1;
    modelReset();
    #1;
    checkOutput("asyncRstQCount", 64'(qCount0), 64'd0);
    checkOutput("asyncRstValid", 64'(outValid0), 64'd0);
    checkOutput("asyncRstOutVal", outVal0, 64'd0);
    seen0.delete();
    seen1.delete();
    seen2.delete();
    seenQ.delete();
    seenDrop.delete();
  endtask

  task automatic checkSeen(input string name, input logic [63:0] got[$], input logic [63:0] exp[$]);
    checkOutput({name, "Pulses"}, 64'(got.size()), 64'(exp.size()));
    for (int i = 0; i < exp.size(); i++) begin
      if (i < got.size()) checkOutput(name, got[i], exp[i]);
    end
  endtask

  // Monitor: compares every cycle, pops the scoreboard on each output pulse
  initial begin
    WindowResult e;
    wait (clkRun);
    forever begin
      @(posedge clk);
      #1;
      checkOutput("qCount", 64'(qCount0), 64'(expQ));
      checkOutput("qCountMax", 64'(qCount2), 64'(expQ));
      checkOutput("dropped", 64'(dropped0), 64'(expDropped));
      checkOutput("droppedMax", 64'(dropped2), 64'(expDropped));
      checkOutput("outValidSum", 64'(outValid0), 64'(expValid));
      checkOutput("outValidCount", 64'(outValid1), 64'(expValid));
      checkOutput("outValidMax", 64'(outValid2), 64'(expValid));
      checkOutput("curBucket", 64'(curBucket0), 64'(epoch % NB));
      checkOutput("holdSum", outVal0, last0);
      checkOutput("holdCount", outVal1, last1);
      checkOutput("holdMax", outVal2, last2);
      if (outValid0) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpectedPulse: got pulse expected none at %0t", $time);
        end else begin
          e = sb.pop_front();
          checkOutput("sbSum", outVal0, e.sum);
          checkOutput("sbCount", outVal1, e.cnt);
          checkOutput("sbMax", outVal2, e.max);
        end
      end
      if (!rst) begin
        if (outValid0) seen0.push_back(outVal0);
        if (outValid1) seen1.push_back(outVal1);
        if (outValid2) seen2.push_back(outVal2);
        seenQ.push_back(int'(qCount0));
        seenDrop.push_back(dropped0);
      end
    end
  end

  // Stimulus: directed scenarios followed by randomized traffic
  initial begin
    logic [63:0] expList[$];
    logic [63:0] r0, r1;
    #3;
    rst = 1'b1;
    modelReset();
    #1;
    checkOutput("rstQCount", 64'(qCount0), 64'd0);
    checkOutput("rstValid", 64'(outValid0), 64'd0);
    checkOutput("rstDropped", 64'(dropped0), 64'd0);
    checkOutput("rstOutVal", outVal0, 64'd0);
    checkOutput("rstOutValMax", outVal2, 64'd0);
    checkOutput("rstCurBucket", 64'(curBucket0), 64'd0);
    clkRun = 1'b1;

    // Sum and slide: 1..4 in cycles 0-3, 5 in cycle 12
    for (int c = 0; c < 18; c++) begin
      if (c < 4) applyStimulus(1'b1, 2'b01, 64'(c + 1), 64'd0);
      else if (c == 12) applyStimulus(1'b1, 2'b01, 64'd5, 64'd0);
      else applyStimulus(1'b1, 2'b00, 64'd0, 64'd0);
    end
    expList = {64'd10, 64'd10, 64'd5};
    checkSeen("slideSum", seen0, expList);
    expList = {64'd4, 64'd4, 64'd1};
    checkSeen("slideCount", seen1, expList);

    // Overflow: both lanes valid in cycles 0-3
    doReset();
    for (int c = 0; c < 6; c++) begin
      if (c < 4) applyStimulus(1'b1, 2'b11, 64'(10 + c), 64'(20 + c));
      else applyStimulus(1'b1, 2'b00, 64'd0, 64'd0);
    end
    checkOutput("ovfQ0", 64'(seenQ[0]), 64'd2);
    checkOutput("ovfQ1", 64'(seenQ[1]), 64'd3);
    checkOutput("ovfQ2", 64'(seenQ[2]), 64'd4);
    checkOutput("ovfQ3", 64'(seenQ[3]), 64'd4);
    checkOutput("ovfDrop2", 64'(seenDrop[2]), 64'd0);
    checkOutput("ovfDrop3", 64'(seenDrop[3]), 64'd1);
    checkOutput("ovfDrop4", 64'(seenDrop[4]), 64'd0);

    // Max with negatives, then windows that go empty
    doReset();
    for (int c = 0; c < 18; c++) begin
      if (c == 0) applyStimulus(1'b1, 2'b01, -64'sd3, 64'd0);
      else if (c == 1) applyStimulus(1'b1, 2'b01, 64'd7, 64'd0);
      else if (c == 2) applyStimulus(1'b1, 2'b01, -64'sd1, 64'd0);
      else applyStimulus(1'b1, 2'b00, 64'd0, 64'd0);
    end
    expList = {64'd7, 64'd7, MOST_NEG};
    checkSeen("maxWin", seen2, expList);
    expList = {64'd3, 64'd3, 64'd0};
    checkSeen("maxWinSum", seen0, expList);

    // Reset mid-operation with two entries queued at cycle 7
    doReset();
    for (int c = 0; c < 7; c++) begin
      if (c == 5) applyStimulus(1'b1, 2'b11, 64'd50, 64'd60);
      else if (c == 6) applyStimulus(1'b1, 2'b01, 64'd70, 64'd0);
      else applyStimulus(1'b1, 2'b00, 64'd0, 64'd0);
    end
    checkOutput("preRstQ", 64'(qCount0), 64'd2);
    doReset();
    applyStimulus(1'b1, 2'b01, 64'd9, 64'd0);
    runIdle(7);
    expList = {64'd9};
    checkSeen("postRst", seen0, expList);

    // Randomized traffic with enable gaps and occasional resets
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 299) == 0) doReset();
      r0 = {$urandom, $urandom};
      r1 = {$urandom, $urandom};
      if ($urandom_range(0, 1) == 1) r0 = {{56{r0[7]}}, r0[7:0]};
      if ($urandom_range(0, 1) == 1) r1 = {{56{r1[7]}}, r1[7:0]};
      applyStimulus(($urandom_range(0, 9) != 0), 2'($urandom_range(0, 3)), r0, r1);
    end
    applyStimulus(1'b0, 2'b00, 64'd0, 64'd0);
    applyStimulus(1'b0, 2'b00, 64'd0, 64'd0);
    @(posedge clk);
    #2;
    checkOutput("sbDrained", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sliding_window_agg.md
SLIDING_WINDOW_AGG -- requirements
Module: sliding_window_agg

Interface
REQ-001 Parameter DATA_W, 64, signed sample width.
REQ-002 Parameter LANES, 2, input lanes presentable per cycle.
REQ-003 Parameter QUEUE_DEPTH, 4, input FIFO entries (power of two, >= LANES).
REQ-004 Parameter NUM_BUCKETS, 2, window buckets (>= 2).
REQ-005 Parameter BUCKET_PERIOD, 5, clock cycles per bucket (>= 2).
REQ-006 Parameter MODE, 0, aggregation: 0 = signed sum, 1 = event count, 2 = signed max.
REQ-007 clk  in  1  single clock, rising edge.
REQ-008 rst  in  1  reset, asynchronous, active-high.
REQ-009 en  in  1  global enable; gates push, pop, timer and output.
REQ-010 input_x  in  LANES*DATA_W  packed samples; lane k in bits [k*DATA_W +: DATA_W].
REQ-011 new_input  in  LANES  per-lane sample-valid.
REQ-012 out_val  out  DATA_W  window aggregate, registered.
REQ-013 out_valid  out  1  one-cycle pulse marking a new out_val.
REQ-014 q_count  out  clog2(QUEUE_DEPTH)+1  FIFO occupancy.
REQ-015 dropped  out  1  one-cycle pulse: at least one sample discarded the previous cycle.
REQ-016 cur_bucket  out  clog2(NUM_BUCKETS)  index of bucket being filled.

Function
REQ-017 With en low, the block SHALL hold all state; samples are ignored and not counted as dropped.
REQ-018 Push: lanes with new_input set SHALL be enqueued in ascending lane order at the clock edge.
REQ-019 Free slots SHALL be QUEUE_DEPTH - q_count + (1 if a pop occurs this cycle); lanes beyond free slots SHALL be discarded and dropped SHALL pulse the following cycle.
REQ-020 Pop: when en high and q_count > 0, exactly one entry (oldest) SHALL be popped per cycle and folded into the current bucket at that edge.
REQ-021 Minimum latency: sample presented in cycle t SHALL be popped in cycle t+1.
REQ-022 Fold rules: sum = two's-complement add, wrapping at DATA_W; count = +1, unsigned wrap at DATA_W; max = signed compare.
REQ-023 Empty-bucket identity: 0 for sum/count, most-negative DATA_W value for max.
REQ-024 Timer SHALL count 0..BUCKET_PERIOD-1 on en-high cycles; expiry cycle is timer == BUCKET_PERIOD-1.
REQ-025 At the expiry edge: out_val SHALL take the aggregate of all NUM_BUCKETS buckets, including the pop of the expiry cycle; out_valid SHALL pulse for the next cycle; timer SHALL return to 0.
REQ-026 At the same edge cur_bucket SHALL advance modulo NUM_BUCKETS, and the newly selected bucket SHALL be set to the identity.
REQ-027 A sample pushed in the expiry cycle SHALL be popped into the new bucket.
REQ-028 Cross-bucket aggregate SHALL use the same fold rules as REQ-022.
REQ-029 out_val SHALL hold between pulses.
REQ-030 Simultaneous push to a full FIFO and pop SHALL accept one lane (REQ-019).

Reset
REQ-031 On rst high, immediately and independent of clk: out_val = 0, out_valid = 0, dropped = 0, q_count = 0, cur_bucket = 0, timer = 0, all buckets = identity, FIFO pointers = 0.
REQ-032 Reset asserted mid-window SHALL discard queued samples and partial buckets; no out_valid pulse SHALL result.
REQ-033 After rst is released, the first expiry SHALL occur BUCKET_PERIOD en-high cycles later.

Verification (defaults unless stated; en rises at cycle 0)
REQ-034 Reset: rst high with clk stopped -> all outputs 0 and q_count 0 without a clock edge.
REQ-035 Sum: lane 0 samples 1, 2, 3, 4 in cycles 0-3 -> out_valid in cycle 5, out_val = 10; next pulse in cycle 10, out_val = 10.
REQ-036 Window slide: continue REQ-035; lane 0 sample 5 in cycle 12 -> pulse in cycle 15, out_val = 5 (bucket holding 10 cleared).
REQ-037 Overflow: both lanes valid, cycles 0-3 -> q_count 2, 3, 4, 4 after each edge; lane 1 of cycle 3 discarded; dropped = 1 in cycle 4 only.
REQ-038 MODE=2: samples -3, 7, -1 -> out_val = 7; following empty window pair -> out_val = 0x8000_0000_0000_0000.
REQ-039 Reset mid-operation: rst pulse at cycle 7 with 2 entries queued -> q_count 0; the first pulse after release carries only post-reset samples.
